// File: rtl/program_loader.sv
// program_loader: boot-time byte-stream loader that packs 3 bytes per 18-bit
// instruction, writes instruction memory, checks an XOR checksum and gates cpu_reset.
`default_nettype none

module program_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 18
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_COUNT = 4'd1,
    S_B0    = 4'd2,
    S_B1    = 4'd3,
    S_B2    = 4'd4,
    S_WRITE = 4'd5,
    S_CHK   = 4'd6,
    S_DONE  = 4'd7,
    S_ERROR = 4'd8
  } state_t;

  state_t                 state, state_nx;
  logic [7:0]             checksum, checksum_nx;
  logic [8:0]             remaining, remaining_nx;
  logic [ADDR_WIDTH-1:0]  addr_nx;
  logic [INSTR_WIDTH-1:0] wdata_nx;
  logic                   accept;

  assign accept = rx_valid && rx_ready;

  always_comb begin
    state_nx     = state;
    checksum_nx  = checksum;
    remaining_nx = remaining;
    addr_nx      = imem_addr;
    wdata_nx     = imem_wdata;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_nx    = S_COUNT;
          checksum_nx = '0;
          addr_nx     = '0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          // A count byte of zero encodes a full 256-instruction image.
          remaining_nx = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          checksum_nx  = checksum ^ rx_data;
          state_nx     = S_B0;
        end
      end
      S_B0: begin
        if (accept) begin
          if (rx_data[7:2] != 6'd0) begin
            state_nx = S_ERROR;
          end else begin
            wdata_nx[INSTR_WIDTH-1 -: 2] = rx_data[1:0];
            checksum_nx                  = checksum ^ rx_data;
            state_nx                     = S_B1;
          end
        end
      end
      S_B1: begin
        if (accept) begin
          wdata_nx[15:8] = rx_data;
          checksum_nx    = checksum ^ rx_data;
          state_nx       = S_B2;
        end
      end
      S_B2: begin
        if (accept) begin
          wdata_nx[7:0] = rx_data;
          checksum_nx   = checksum ^ rx_data;
          state_nx      = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_nx      = imem_addr + 1'b1;
        remaining_nx = remaining - 9'd1;
        state_nx     = (remaining == 9'd1) ? S_CHK : S_B0;
      end
      S_CHK: begin
        if (accept) begin
          state_nx = (rx_data == checksum) ? S_DONE : S_ERROR;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      checksum   <= '0;
      remaining  <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nx;
      checksum   <= checksum_nx;
      remaining  <= remaining_nx;
      imem_addr  <= addr_nx;
      imem_wdata <= wdata_nx;
      rx_ready   <= (state_nx inside {S_COUNT, S_B0, S_B1, S_B2, S_CHK});
      imem_we    <= (state_nx == S_WRITE);
      busy       <= (state_nx inside {S_COUNT, S_B0, S_B1, S_B2, S_WRITE, S_CHK});
      cpu_reset  <= (state_nx != S_DONE);
      done       <= (state_nx == S_DONE);
      error      <= (state_nx == S_ERROR);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven and randomized checks of program_loader
// against a stream-parsing reference model.
`default_nettype none

module tb_program_loader;

  typedef logic [7:0] bq_t [$];
  typedef struct { int addr; int data; } wr_t;
  typedef struct {
    int         len;
    logic [7:0] b [12];
    int         exp_writes;
    int         exp_d0;
    bit         exp_done;
    bit         exp_error;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready, imem_we, cpu_reset, busy, done, error;
  logic [7:0]  imem_addr;
  logic [17:0] imem_wdata;

  int  n_checks = 0;
  int  n_fail = 0;
  wr_t cap_q[$];
  wr_t exp_q[$];
  bit  exp_done, exp_error;
  vec_t vt [7];

  program_loader #(.ADDR_WIDTH(8), .INSTR_WIDTH(18)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  always @(negedge clock) begin
    if (imem_we) begin
      wr_t w;
      w.addr = int'(imem_addr);
      w.data = int'(imem_wdata);
      cap_q.push_back(w);
      chk("we_rx_ready_low", int'(rx_ready), 0);
      chk("we_busy_high", int'(busy), 1);
    end
  end

  // Reference: parse the stream by its format rules into writes and an outcome.
  task automatic model(input bq_t b);
    int n, idx;
    logic [7:0] cs, x;
    wr_t w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_error = 1'b0;
    n = (b[0] == 8'd0) ? 256 : int'(b[0]);
    cs = b[0];
    idx = 1;
    for (int i = 0; i < n; i++) begin
      x = b[idx];
      if (x[7:2] != 6'd0) begin
        exp_error = 1'b1;
        return;
      end
      cs = cs ^ b[idx] ^ b[idx+1] ^ b[idx+2];
      w.addr = i % 256;
      w.data = int'({x[1:0], b[idx+1], b[idx+2]});
      exp_q.push_back(w);
      idx += 3;
    end
    if (b[idx] == cs) exp_done = 1'b1;
    else exp_error = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input string nm, output bit ok);
    int t = 0;
    rx_valid = 1'b1;
    rx_data = v;
    while (!rx_ready && t < 20) begin
      @(negedge clock);
      t++;
    end
    ok = rx_ready;
    if (!ok) chk({nm, " accept_timeout"}, 0, 1);
    else @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic run_stream(input bq_t b, input int maxgap, input bit midstart, input string nm);
    bit ok;
    cap_q.delete();
    pulse_start();
    foreach (b[i]) begin
      if (error) break;
      repeat ($urandom_range(0, maxgap)) begin
        if (midstart && $urandom_range(0, 1) == 1) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      send_byte(b[i], nm, ok);
      if (!ok) break;
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic check_run(input string nm);
    int m;
    chk({nm, " nwrites"}, cap_q.size(), exp_q.size());
    m = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk({nm, " waddr"}, cap_q[i].addr, exp_q[i].addr);
      chk({nm, " wdata"}, cap_q[i].data, exp_q[i].data);
    end
    chk({nm, " done"}, int'(done), int'(exp_done));
    chk({nm, " error"}, int'(error), int'(exp_error));
    chk({nm, " cpu_reset"}, int'(cpu_reset), int'(!exp_done));
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " rx_ready"}, int'(rx_ready), 0);
    if (exp_done) chk({nm, " final_addr"}, int'(imem_addr), exp_q.size() % 256);
  endtask

  initial begin
    bq_t q;
    bit ok;
    logic [7:0] cs, b0;
    logic [17:0] ins;

    vt[0] = '{8, '{8'h02,8'h01,8'h23,8'h45,8'h00,8'hAB,8'hCD,8'h03,8'h00,8'h00,8'h00,8'h00}, 2, 'h12345, 1'b1, 1'b0};
    vt[1] = '{8, '{8'h02,8'h01,8'h23,8'h45,8'h00,8'hAB,8'hCD,8'h04,8'h00,8'h00,8'h00,8'h00}, 2, 'h12345, 1'b0, 1'b1};
    vt[2] = '{8, '{8'h02,8'h01,8'h23,8'h45,8'h00,8'hAB,8'hCD,8'h03,8'h00,8'h00,8'h00,8'h00}, 2, 'h12345, 1'b1, 1'b0};
    vt[3] = '{2, '{8'h01,8'h05,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 0, 1'b0, 1'b1};
    vt[4] = '{5, '{8'h01,8'h02,8'hFF,8'hEE,8'h12,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 'h2FFEE, 1'b1, 1'b0};
    vt[5] = '{8, '{8'h02,8'h03,8'h11,8'h22,8'h04,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 'h31122, 1'b0, 1'b1};
    vt[6] = '{5, '{8'h01,8'h00,8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 1, 0, 1'b1, 1'b0};

    // Reset values
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst rx_ready", int'(rx_ready), 0);
    chk("rst imem_we", int'(imem_we), 0);
    chk("rst imem_addr", int'(imem_addr), 0);
    chk("rst imem_wdata", int'(imem_wdata), 0);
    chk("rst cpu_reset", int'(cpu_reset), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst error", int'(error), 0);

    // Table-driven streams, applied back to back (restarts from DONE/ERROR)
    for (int r = 0; r < 7; r++) begin
      string nm;
      nm = $sformatf("tbl%0d", r);
      q.delete();
      for (int k = 0; k < vt[r].len; k++) q.push_back(vt[r].b[k]);
      model(q);
      run_stream(q, 0, 1'b0, nm);
      check_run(nm);
      chk({nm, " tbl_writes"}, cap_q.size(), vt[r].exp_writes);
      chk({nm, " tbl_done"}, int'(done), int'(vt[r].exp_done));
      chk({nm, " tbl_error"}, int'(error), int'(vt[r].exp_error));
      if (vt[r].exp_writes > 0 && cap_q.size() > 0)
        chk({nm, " tbl_d0"}, cap_q[0].data, vt[r].exp_d0);
    end

    // Gapped stream with start pulses during the load
    q.delete();
    for (int k = 0; k < 8; k++) q.push_back(vt[0].b[k]);
    model(q);
    run_stream(q, 3, 1'b1, "gapped");
    check_run("gapped");
    chk("gapped writes", cap_q.size(), 2);
    chk("gapped done", int'(done), 1);

    // Randomized streams: valid, bad checksum, or bad format byte
    for (int it = 0; it < 25; it++) begin
      int n, mode, badg;
      n = $urandom_range(1, 6);
      mode = $urandom_range(0, 3);
      badg = $urandom_range(0, n - 1);
      q.delete();
      cs = n[7:0];
      q.push_back(n[7:0]);
      for (int g = 0; g < n; g++) begin
        ins = 18'($urandom);
        b0 = {6'd0, ins[17:16]};
        if (mode == 2 && g == badg) b0[7:2] = 6'($urandom_range(1, 63));
        q.push_back(b0);
        q.push_back(ins[15:8]);
        q.push_back(ins[7:0]);
        cs = cs ^ b0 ^ ins[15:8] ^ ins[7:0];
      end
      if (mode == 1) cs = cs ^ 8'h5A;
      q.push_back(cs);
      model(q);
      run_stream(q, 3, 1'b1, "rand");
      check_run("rand");
    end

    // Full 256-instruction image with address wrap
    q.delete();
    cs = 8'h00;
    q.push_back(8'h00);
    for (int g = 0; g < 256; g++) begin
      ins = 18'($urandom);
      b0 = {6'd0, ins[17:16]};
      q.push_back(b0);
      q.push_back(ins[15:8]);
      q.push_back(ins[7:0]);
      cs = cs ^ b0 ^ ins[15:8] ^ ins[7:0];
    end
    q.push_back(cs);
    model(q);
    run_stream(q, 0, 1'b0, "full256");
    check_run("full256");
    chk("full256 count", cap_q.size(), 256);
    if (cap_q.size() > 0) chk("full256 last_addr", cap_q[$].addr, 255);
    chk("full256 addr_wrapped", int'(imem_addr), 0);

    // Asynchronous reset in the middle of a group
    cap_q.delete();
    pulse_start();
    send_byte(8'h01, "midrst", ok);
    send_byte(8'h01, "midrst", ok);
    send_byte(8'h22, "midrst", ok);
    #2 reset = 1'b1;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst rx_ready", int'(rx_ready), 0);
    chk("midrst cpu_reset", int'(cpu_reset), 1);
    chk("midrst wdata", int'(imem_wdata), 0);
    chk("midrst we", int'(imem_we), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'h33;
    repeat (4) @(negedge clock);
    chk("midrst idle_rx_ready", int'(rx_ready), 0);
    chk("midrst idle_busy", int'(busy), 0);
    rx_valid = 1'b0;
    chk("midrst no_write", cap_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
